// File: rtl/switch_press_classifier_if.sv
// Bundle for the debounced switch level and the classifier's event outputs.
// master = switch source / event consumer side, slave = classifier side.
interface switch_press_classifier_if;
    logic i_Switch;
    logic o_Rise;
    logic o_Fall;
    logic o_Short;
    logic o_Long;
    logic o_Double;
    logic o_Busy;

    modport master (
        output i_Switch,
        input  o_Rise, o_Fall, o_Short, o_Long, o_Double, o_Busy
    );

    modport slave (
        input  i_Switch,
        output o_Rise, o_Fall, o_Short, o_Long, o_Double, o_Busy
    );
endinterface

// File: rtl/switch_press_classifier.sv
// Classifies debounced switch presses as SHORT, LONG or DOUBLE and emits
// one-cycle registered event pulses plus raw press/release edge pulses.
module switch_press_classifier #(
    parameter int c_LONG_LIMIT = 12500000,
    parameter int c_GAP_LIMIT  = 5000000,
    parameter int c_CNT_W      = 24
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_L,
    switch_press_classifier_if.slave  sw_bus
);
    localparam logic [c_CNT_W-1:0] c_LONG_CMP = c_CNT_W'(c_LONG_LIMIT);
    localparam logic [c_CNT_W-1:0] c_GAP_CMP  = c_CNT_W'(c_GAP_LIMIT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {IDLE, PRESSED, GAP, WAIT_REL} state_t;

    state_t             state_reg;
    logic [c_CNT_W-1:0] count_reg;
    logic               prev_reg;
    logic               rise_reg, fall_reg, short_reg, long_reg, double_reg, busy_reg;

    logic               sw;
    logic               rise;
    logic               fall;
    logic [c_CNT_W-1:0] count_inc;

    assign sw   = sw_bus.i_Switch;
    assign rise = sw & ~prev_reg;
    assign fall = ~sw & prev_reg;
    // Counter holds at all-ones rather than wrapping back into a valid range.
    assign count_inc = (count_reg == c_CNT_MAX) ? count_reg : count_reg + c_CNT_ONE;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            prev_reg   <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            short_reg  <= 1'b0;
            long_reg   <= 1'b0;
            double_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            prev_reg   <= sw;
            rise_reg   <= rise;
            fall_reg   <= fall;
            short_reg  <= 1'b0;
            long_reg   <= 1'b0;
            double_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        state_reg <= PRESSED;
                        count_reg <= c_CNT_ONE;
                        busy_reg  <= 1'b1;
                    end
                end
                PRESSED: begin
                    // A release checked first means release beats a simultaneous long hit.
                    if (!sw) begin
                        state_reg <= GAP;
                        count_reg <= c_CNT_ONE;
                    end else if (count_reg == c_LONG_CMP) begin
                        long_reg  <= 1'b1;
                        state_reg <= WAIT_REL;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_inc;
                    end
                end
                GAP: begin
                    if (rise) begin
                        double_reg <= 1'b1;
                        state_reg  <= WAIT_REL;
                        count_reg  <= '0;
                    end else if (count_reg == c_GAP_CMP) begin
                        short_reg <= 1'b1;
                        state_reg <= IDLE;
                        count_reg <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        count_reg <= count_inc;
                    end
                end
                WAIT_REL: begin
                    if (!sw) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign sw_bus.o_Rise   = rise_reg;
    assign sw_bus.o_Fall   = fall_reg;
    assign sw_bus.o_Short  = short_reg;
    assign sw_bus.o_Long   = long_reg;
    assign sw_bus.o_Double = double_reg;
    assign sw_bus.o_Busy   = busy_reg;
endmodule

// File: tb/tb_switch_press_classifier.sv
// Drives directed and random press patterns into the classifier and compares every
// output each cycle against a timestamp-based model of the press rules.
module tb_switch_press_classifier;
    localparam int LONG_LIMIT = 8;
    localparam int GAP_LIMIT  = 4;
    localparam int CNT_W      = 4;

    logic i_Clk = 1'b0;
    logic i_Rst_L = 1'b0;

    switch_press_classifier_if sw_bus ();

    switch_press_classifier #(
        .c_LONG_LIMIT (LONG_LIMIT),
        .c_GAP_LIMIT  (GAP_LIMIT),
        .c_CNT_W      (CNT_W)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .sw_bus  (sw_bus)
    );

    always #5 i_Clk = ~i_Clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int txn = 0;

    // Reference model: a press sequence is described by when it started and when it was released.
    logic m_prev, m_active, m_released, m_resolved;
    int   press_t, rel_t;
    logic exp_rise, exp_fall, exp_short, exp_long, exp_double, exp_busy;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all(input string phase);
        check({phase, ".rise"},   sw_bus.o_Rise,   exp_rise);
        check({phase, ".fall"},   sw_bus.o_Fall,   exp_fall);
        check({phase, ".short"},  sw_bus.o_Short,  exp_short);
        check({phase, ".long"},   sw_bus.o_Long,   exp_long);
        check({phase, ".double"}, sw_bus.o_Double, exp_double);
        check({phase, ".busy"},   sw_bus.o_Busy,   exp_busy);
    endtask

    task automatic model_reset();
        m_prev = 0; m_active = 0; m_released = 0; m_resolved = 0;
        exp_rise = 0; exp_fall = 0; exp_short = 0; exp_long = 0; exp_double = 0; exp_busy = 0;
    endtask

    task automatic model_update(input logic sw);
        int t;
        logic r, f;
        cyc++;
        t = cyc;
        r = sw && !m_prev;
        f = !sw && m_prev;
        m_prev = sw;
        exp_rise = r; exp_fall = f;
        exp_short = 0; exp_long = 0; exp_double = 0;
        if (!m_active) begin
            if (r) begin
                m_active = 1; m_released = 0; m_resolved = 0; press_t = t;
            end
        end else if (m_resolved) begin
            if (!sw) m_active = 0;
        end else if (!m_released) begin
            if (!sw) begin
                m_released = 1; rel_t = t;
            end else if (t - press_t == LONG_LIMIT) begin
                exp_long = 1; m_resolved = 1;
            end
        end else begin
            if (sw) begin
                exp_double = 1; m_resolved = 1;
            end else if (t - rel_t == GAP_LIMIT) begin
                exp_short = 1; m_active = 0;
            end
        end
        exp_busy = m_active;
    endtask

    task automatic step(input logic sw, input string phase);
        sw_bus.i_Switch = sw;
        @(posedge i_Clk);
        model_update(sw);
        #1;
        check_all(phase);
    endtask

    task automatic run(input logic sw, input int n, input string phase);
        for (int i = 0; i < n; i++) step(sw, phase);
    endtask

    task automatic apply_reset(input int n, input logic sw_at_release);
        i_Rst_L = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        for (int i = 0; i < n; i++) begin
            sw_bus.i_Switch = i[0];
            @(posedge i_Clk);
            cyc++;
            #1;
            check_all("rst_hold");
        end
        sw_bus.i_Switch = sw_at_release;
        i_Rst_L = 1'b1;
    endtask

    task automatic press(input int hi, input int lo, input string phase);
        txn++;
        $display("txn %0d %s high=%0d low=%0d", txn, phase, hi, lo);
        run(1'b1, hi, phase);
        run(1'b0, lo, phase);
    endtask

    initial begin
        sw_bus.i_Switch = 1'b0;
        model_reset();
        @(posedge i_Clk);
        #1;
        apply_reset(5, 1'b0);
        run(1'b0, 3, "idle");

        press(3, 8, "short");
        press(20, 3, "long");
        txn++; $display("txn %0d double", txn);
        run(1'b1, 2, "double"); run(1'b0, 2, "double");
        run(1'b1, 3, "double"); run(1'b0, 4, "double");

        press(8, 7, "rel_at_limit");
        press(9, 3, "long_at_limit");
        txn++; $display("txn %0d gap_at_limit", txn);
        run(1'b1, 2, "gap4"); run(1'b0, 4, "gap4");
        run(1'b1, 2, "gap4"); run(1'b0, 3, "gap4");
        txn++; $display("txn %0d gap_past_limit", txn);
        run(1'b1, 2, "gap5"); run(1'b0, 5, "gap5");
        run(1'b1, 2, "gap5"); run(1'b0, 7, "gap5");

        txn++; $display("txn %0d reset_in_gap", txn);
        run(1'b1, 3, "rst_gap"); run(1'b0, 2, "rst_gap");
        apply_reset(3, 1'b0);
        run(1'b0, 6, "after_rst_gap");
        txn++; $display("txn %0d reset_in_pressed", txn);
        run(1'b1, 3, "rst_pr");
        apply_reset(3, 1'b1);
        run(1'b1, 2, "after_rst_high");
        run(1'b0, 7, "after_rst_high");

        for (int k = 0; k < 40; k++) begin
            int hi, lo;
            hi = $urandom_range(12, 1);
            lo = $urandom_range(7, 1);
            press(hi, lo, "rand");
            if ($urandom_range(9, 0) == 0) begin
                logic s;
                s = 1'($urandom_range(1, 0));
                apply_reset($urandom_range(3, 1), s);
                run(s, 2, "rand_after_rst");
            end
        end
        run(1'b0, 8, "drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
